fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and fetch controller for the 9-bit-instruction CPU.
- Drives the 8-bit address of the combinational instruction ROM and registers the returned 9-bit word into an instruction register.
- Presents that word to decode over a valid/ready handshake.
- Handles start, branch redirect with squash, back-pressure, halt detection, and PC wrap-around. Sits between the instruction ROM and the decode stage.

Parameters:
- RESET_PC, 8'd0, PC loaded on reset and on start.
- HALT_WORD, 9'b0000_00_000, instruction encoding that ends fetching.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin fetching from RESET_PC; honoured only in IDLE or HALTED.
- rom_address  output  8  address to instruction ROM; equals pc at all times.
- rom_instruction  input  9  ROM data for rom_address, valid in the same cycle.
- instr  output  9  registered instruction to decode.
- instr_valid  output  1  instr holds a live instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- branch_taken  input  1  one-cycle redirect request from execute.
- branch_target  input  8  new PC when branch_taken is high.
- busy  output  1  high in FETCH or DRAIN.
- halted  output  1  high in HALTED.
- fetch_count  output  CNT_W  number of completed handshakes since the last start.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation) sets:
  - state to IDLE, pc to RESET_PC, instr to 0, instr_valid to 0, fetch_count to 0.
  - busy and halted are decoded from state, so both are 0 after reset.
- rom_address = pc, driven combinationally from the pc register. The ROM is combinational, so fetch latency is one cycle from pc to instr.
- Handshake:
  - Completes when instr_valid && instr_ready && !branch_taken.
  - On completion, fetch_count increments and wraps at 2^CNT_W-1 to 0.
  - instr and instr_valid are held stable while instr_valid && !instr_ready.
- The slot is free when !instr_valid || handshake completes.
- States: IDLE, FETCH, DRAIN, HALTED.
- IDLE:
  - instr_valid is 0.
  - start loads pc to RESET_PC, clears fetch_count, and moves to FETCH.
  - branch_taken is ignored.
- FETCH, in priority order:
  1. branch_taken: pc <= branch_target, instr_valid <= 0 (squash, no handshake counted), no fetch this cycle, stay in FETCH.
  2. Slot free and rom_instruction == HALT_WORD: instr <= HALT_WORD, instr_valid <= 1, pc unchanged, go to DRAIN.
  3. Slot free, any other word: instr <= rom_instruction, instr_valid <= 1, pc <= pc+1 modulo 256 (255 wraps to 0).
  4. Slot not free: hold all state.
- DRAIN (the halt word is waiting in instr):
  - branch_taken: squash as in FETCH, pc <= branch_target, return to FETCH.
  - Handshake completes: instr_valid <= 0, go to HALTED. The halt word itself is counted.
- HALTED:
  - instr_valid is 0, pc is frozen, and fetch_count is held for inspection.
  - start behaves as in IDLE.
  - branch_taken is ignored.
- start asserted in FETCH or DRAIN is ignored.
- branch_taken has priority over instr_ready in the same cycle.

Test Plan:
1. Reset, then start with instr_ready=1 and ROM words 0x15F, 0x160, 0x0B1 at addresses 0..2 -> rom_address steps 0,1,2. instr_valid rises 1 cycle after start+1. instr reads 0x15F, 0x160, 0x0B1 on consecutive cycles. fetch_count=3 after the third.
2. Back-pressure: hold instr_ready=0 for 4 cycles while instr=0x160 -> instr, instr_valid and rom_address are frozen and fetch_count does not change. Release -> next word is delivered the following cycle with no skipped or duplicated instruction.
3. Branch: branch_taken=1 with branch_target=8'h40 while instr_valid=1 and instr_ready=1 -> next cycle instr_valid=0, rom_address=0x40, fetch_count unchanged. The following cycle instr equals ROM[0x40].
4. Halt: ROM[5]=HALT_WORD -> instr=0x000, valid, pc stays 5. After the handshake, halted=1, busy=0, fetch_count=6, and no further address change. A later start restarts at RESET_PC with fetch_count=0.
5. Wrap-around: branch to 0xFE with ROM nonzero at 0xFE and 0xFF -> rom_address goes 0xFE, 0xFF, 0x00, and fetching continues.
6. Reset mid-operation: assert reset in DRAIN with instr_valid=1 -> next cycle state is IDLE, instr_valid=0, instr=0, pc=RESET_PC, fetch_count=0, and start is required to resume.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the 9-bit-instruction CPU.
// Addresses a combinational instruction ROM, registers the returned word and
// hands it to decode over a valid/ready handshake. Handles start, branch
// squash, back-pressure, halt detection and PC wrap-around.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC  = 8'd0,
  parameter logic [8:0]  HALT_WORD = 9'b0000_00_000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       rom_address,
  input  logic [8:0]       rom_instruction,
  output logic [8:0]       instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch_taken,
  input  logic [7:0]       branch_target,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalted} state_e;

  state_e           r_state;
  logic [7:0]       r_pc;
  logic [8:0]       r_instr;
  logic             r_instr_valid;
  logic [CNT_W-1:0] r_fetch_count;

  logic w_handshake;
  logic w_slot_free;
  logic w_is_halt;

  // A branch in the same cycle squashes the transfer, so it never counts.
  assign w_handshake = r_instr_valid && instr_ready && !branch_taken;
  assign w_slot_free = !r_instr_valid || w_handshake;
  assign w_is_halt   = (rom_instruction == HALT_WORD);

  // Control FSM, program counter, instruction register and delivered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_instr       <= 9'd0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // Valid is only ever high in FETCH/DRAIN, so counting here is safe in
      // every state; a start below overrides it with the clear.
      if (w_handshake) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end

      case (r_state)
        StIdle, StHalted: begin
          if (start) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_state       <= StFetch;
          end
        end

        StFetch: begin
          if (branch_taken) begin
            r_pc          <= branch_target;
            r_instr_valid <= 1'b0;
          end else if (w_slot_free) begin
            r_instr       <= rom_instruction;
            r_instr_valid <= 1'b1;
            if (w_is_halt) begin
              // PC stays on the halt word so the address stops moving.
              r_state <= StDrain;
            end else begin
              r_pc <= r_pc + 8'd1;
            end
          end
        end

        StDrain: begin
          if (branch_taken) begin
            r_pc          <= branch_target;
            r_instr_valid <= 1'b0;
            r_state       <= StFetch;
          end else if (w_handshake) begin
            r_instr_valid <= 1'b0;
            r_state       <= StHalted;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs come straight from registers; status is decoded from state.
  assign rom_address = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_count = r_fetch_count;
  assign busy        = (r_state == StFetch) || (r_state == StDrain);
  assign halted      = (r_state == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of one-cycle vectors with
// hand-computed expectations, plus hand-written multi-cycle sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rom_address;
  logic [8:0]  rom_instruction;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_count;

  logic [8:0] rom [256];

  int n_vec;
  int n_miss;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic [7:0]  e_addr;
    logic [8:0]  e_instr;
    logic        e_valid;
    logic        e_busy;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .busy            (busy),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  assign rom_instruction = rom[rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic st, input logic rdy, input logic br,
                     input logic [7:0] tgt, input logic [7:0] e_addr, input logic [8:0] e_instr,
                     input logic e_valid, input logic e_busy, input logic e_halted,
                     input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_valid = e_valid;
    v.e_busy = e_busy; v.e_halted = e_halted; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the edge, clock once, settle.
  task automatic step(input logic rst, input logic st, input logic rdy, input logic br,
                      input logic [7:0] tgt);
    @(negedge clk);
    reset = rst; start = st; instr_ready = rdy; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] e_addr, input logic [8:0] e_instr,
                       input logic e_valid, input logic e_busy, input logic e_halted,
                       input logic [15:0] e_cnt);
    n_vec++;
    if ({rom_address, instr, instr_valid, busy, halted, fetch_count} !==
        {e_addr, e_instr, e_valid, e_busy, e_halted, e_cnt}) begin
      n_miss++;
      $display("FAIL %s: got addr=%h instr=%h v=%b busy=%b halted=%b cnt=%0d, want addr=%h instr=%h v=%b busy=%b halted=%b cnt=%0d",
               name, rom_address, instr, instr_valid, busy, halted, fetch_count,
               e_addr, e_instr, e_valid, e_busy, e_halted, e_cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 256; i++) rom[i] = 9'h100 | 9'(i);
    rom[0] = 9'h15F;
    rom[1] = 9'h160;
    rom[2] = 9'h0B1;
    rom[5] = 9'h000;

    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;

    //   rst st rdy br tgt     addr   instr   v  bsy hlt cnt
    // Start and three consecutive fetches, with back-pressure on 0x160.
    add(0, 1, 1, 0, 8'h00, 8'h00, 9'h000, 0, 1, 0, 16'd0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 9'h15F, 1, 1, 0, 16'd0);
    add(0, 0, 1, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd1);
    add(0, 0, 0, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd1);
    add(0, 0, 0, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd1);
    add(0, 0, 0, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd1);
    add(0, 0, 0, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd1);
    add(0, 0, 1, 0, 8'h00, 8'h03, 9'h0B1, 1, 1, 0, 16'd2);
    add(0, 0, 1, 0, 8'h00, 8'h04, 9'h103, 1, 1, 0, 16'd3);
    add(0, 0, 1, 0, 8'h00, 8'h05, 9'h104, 1, 1, 0, 16'd4);
    // Halt word at address 5; start during DRAIN is ignored.
    add(0, 0, 1, 0, 8'h00, 8'h05, 9'h000, 1, 1, 0, 16'd5);
    add(0, 1, 0, 0, 8'h00, 8'h05, 9'h000, 1, 1, 0, 16'd5);
    add(0, 0, 1, 0, 8'h00, 8'h05, 9'h000, 0, 0, 1, 16'd6);
    // Branch ignored while halted, then restart.
    add(0, 0, 1, 1, 8'h40, 8'h05, 9'h000, 0, 0, 1, 16'd6);
    add(0, 1, 1, 0, 8'h00, 8'h00, 9'h000, 0, 1, 0, 16'd0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 9'h15F, 1, 1, 0, 16'd0);
    // Branch beats ready: squash, no count.
    add(0, 0, 1, 1, 8'h40, 8'h40, 9'h15F, 0, 1, 0, 16'd0);
    add(0, 0, 1, 0, 8'h00, 8'h41, 9'h140, 1, 1, 0, 16'd0);
    add(0, 0, 1, 0, 8'h00, 8'h42, 9'h141, 1, 1, 0, 16'd1);
    add(0, 1, 1, 0, 8'h00, 8'h43, 9'h142, 1, 1, 0, 16'd2);
    // PC wrap-around 0xFE, 0xFF, 0x00.
    add(0, 0, 0, 1, 8'hFE, 8'hFE, 9'h142, 0, 1, 0, 16'd2);
    add(0, 0, 1, 0, 8'h00, 8'hFF, 9'h1FE, 1, 1, 0, 16'd2);
    add(0, 0, 1, 0, 8'h00, 8'h00, 9'h1FF, 1, 1, 0, 16'd3);
    add(0, 0, 1, 0, 8'h00, 8'h01, 9'h15F, 1, 1, 0, 16'd4);
    add(0, 0, 1, 0, 8'h00, 8'h02, 9'h160, 1, 1, 0, 16'd5);

    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    check("reset", 8'h00, 9'h000, 0, 0, 0, 16'd0);
    step(0, 0, 1, 1, 8'h40);
    check("idle_ignores_branch", 8'h00, 9'h000, 0, 0, 0, 16'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_valid,
            vecs[i].e_busy, vecs[i].e_halted, vecs[i].e_cnt);
    end

    // Branch while the halt word waits in DRAIN returns to FETCH.
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    check("to_pc5", 8'h05, 9'h104, 1, 1, 0, 16'd8);
    step(0, 0, 1, 0, 8'h00);
    check("drain_again", 8'h05, 9'h000, 1, 1, 0, 16'd9);
    step(0, 0, 1, 1, 8'h10);
    check("drain_branch", 8'h10, 9'h000, 0, 1, 0, 16'd9);
    step(0, 0, 1, 0, 8'h00);
    check("after_drain_branch", 8'h11, 9'h110, 1, 1, 0, 16'd9);

    // Reset in DRAIN with a live halt word, even with ready high.
    step(0, 0, 1, 1, 8'h05);
    step(0, 0, 0, 0, 8'h00);
    check("drain_before_reset", 8'h05, 9'h000, 1, 1, 0, 16'd9);
    step(0, 0, 1, 1, 8'h00);
    check("drain_squash", 8'h00, 9'h000, 0, 1, 0, 16'd9);
    step(0, 0, 1, 1, 8'h05);
    step(0, 0, 1, 0, 8'h00);
    check("drain_third", 8'h05, 9'h000, 1, 1, 0, 16'd9);
    step(1, 1, 1, 0, 8'h00);
    check("reset_mid_drain", 8'h00, 9'h000, 0, 0, 0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 8'h40);
      check($sformatf("idle_wait%0d", k), 8'h00, 9'h000, 0, 0, 0, 16'd0);
    end
    step(0, 1, 1, 0, 8'h00);
    check("restart", 8'h00, 9'h000, 0, 1, 0, 16'd0);
    step(0, 0, 1, 0, 8'h00);
    check("restart_first", 8'h01, 9'h15F, 1, 1, 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
